hazard_controller: RTL and testbench

Pipeline hazard controller for the 5-stage core. It sits beside the decode stage and tracks the destination registers of the instructions in EXE and MEM. From the decode instruction it produces registered rs/rt forwarding selects for the EXE operand muxes. It also sequences pipeline stalls and bubble insertion for load-use hazards and for HI/LO accesses while the multi-cycle mul/div unit is busy.

---
 rtl/hazard_pkg.sv | 22 ++
 rtl/hazard_controller_if.sv | 34 +++
 rtl/dest_history.sv | 29 ++
 rtl/hazard_controller.sv | 108 ++++++++++
 tb/tb_hazard_controller.sv | 345 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared types and instruction field positions for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN,
        LOAD_STALL,
        HILO_WAIT
    } hazard_state_e;

    typedef struct packed {
        logic [4:0] dest;
        logic       isLoad;
    } slot_t;

    localparam int unsigned RS_MSB = 25;
    localparam int unsigned RS_LSB = 21;
    localparam int unsigned RT_MSB = 20;
    localparam int unsigned RT_LSB = 16;
    localparam int unsigned RD_MSB = 15;
    localparam int unsigned RD_LSB = 11;

endpackage

// File: rtl/hazard_controller_if.sv
// Decode-side inputs and EXE-side control outputs of the hazard controller.
interface hazard_controller_if;
    import hazard_pkg::*;

    logic [31:0]   Instr;
    logic          ValidID;
    logic          RegWrite;
    logic          RegDest;
    logic          UsesRt;
    logic          MemRead;
    logic          MulDivStart;
    logic          HiLoAccess;
    logic          Stall;
    logic          Bubble;
    logic          forwardFromExe2rs;
    logic          forwardFromExe2rt;
    logic          forwardFromMem2rs;
    logic          forwardFromMem2rt;
    logic          MulDivBusy;
    hazard_state_e state;

    modport master (
        output Instr, ValidID, RegWrite, RegDest, UsesRt, MemRead, MulDivStart, HiLoAccess,
        input  Stall, Bubble, forwardFromExe2rs, forwardFromExe2rt, forwardFromMem2rs,
               forwardFromMem2rt, MulDivBusy, state
    );

    modport slave (
        input  Instr, ValidID, RegWrite, RegDest, UsesRt, MemRead, MulDivStart, HiLoAccess,
        output Stall, Bubble, forwardFromExe2rs, forwardFromExe2rt, forwardFromMem2rs,
               forwardFromMem2rt, MulDivBusy, state
    );

endinterface

// File: rtl/dest_history.sv
// Two-slot EXE/MEM destination history; a stall pushes an empty slot into EXE.
module dest_history
    import hazard_pkg::*;
(
    input  logic  CLK,
    input  logic  RESET,
    input  logic  stall,
    input  slot_t id_slot,
    output slot_t exe_slot,
    output slot_t mem_slot
);

    slot_t exe_q;
    slot_t mem_q;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            exe_q <= '0;
            mem_q <= '0;
        end else begin
            mem_q <= exe_q;
            exe_q <= stall ? '0 : id_slot;
        end
    end

    assign exe_slot = exe_q;
    assign mem_slot = mem_q;

endmodule

// File: rtl/hazard_controller.sv
// Load-use / HI-LO stall sequencing and registered EXE operand forwarding selects.
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int unsigned MULDIV_LATENCY = 4,  // 1..15, must fit in CNT_W bits
    parameter int unsigned CNT_W          = 4
) (
    input logic                CLK,
    input logic                RESET,
    hazard_controller_if.slave hz
);

    logic [4:0]       dest;
    logic [4:0]       src_rs;
    logic [4:0]       src_rt;
    slot_t            id_slot;
    slot_t            exe_slot;
    slot_t            mem_slot;
    logic             load_use;
    logic             hilo_haz;
    logic             stall;
    logic             exe2rs;
    logic             exe2rt;
    logic             mem2rs;
    logic             mem2rt;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [3:0]       fwd_q;
    logic             bubble_q;
    logic             busy_q;
    hazard_state_e    state_q;
    logic             unused_instr;

    assign unused_instr = ^{hz.Instr[31:26], hz.Instr[10:0]};

    always_comb begin
        dest = '0;
        if (hz.ValidID && hz.RegWrite) begin
            dest = hz.RegDest ? hz.Instr[RD_MSB:RD_LSB] : hz.Instr[RT_MSB:RT_LSB];
        end
        src_rs = hz.ValidID ? hz.Instr[RS_MSB:RS_LSB] : '0;
        src_rt = (hz.ValidID && hz.UsesRt) ? hz.Instr[RT_MSB:RT_LSB] : '0;
    end

    assign id_slot = '{dest: dest, isLoad: hz.MemRead && hz.ValidID};

    dest_history u_dest_history (
        .CLK      (CLK),
        .RESET    (RESET),
        .stall    (stall),
        .id_slot  (id_slot),
        .exe_slot (exe_slot),
        .mem_slot (mem_slot)
    );

    assign load_use = exe_slot.isLoad && (exe_slot.dest != '0) &&
                      ((exe_slot.dest == src_rs) || (exe_slot.dest == src_rt));
    assign hilo_haz = (hz.HiLoAccess || hz.MulDivStart) && hz.ValidID && (cnt_q != '0);
    assign stall    = load_use || hilo_haz;

    // EXE match wins over MEM since it holds the younger result.
    assign exe2rs = (exe_slot.dest != '0) && (exe_slot.dest == src_rs);
    assign exe2rt = (exe_slot.dest != '0) && (exe_slot.dest == src_rt);
    assign mem2rs = (mem_slot.dest != '0) && (mem_slot.dest == src_rs) && !exe2rs;
    assign mem2rt = (mem_slot.dest != '0) && (mem_slot.dest == src_rt) && !exe2rt;

    always_comb begin
        cnt_d = cnt_q;
        if (!stall && hz.ValidID && hz.MulDivStart) begin
            cnt_d = CNT_W'(MULDIV_LATENCY);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // State only mirrors the hazard equations; Stall never depends on it.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q  <= RUN;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            bubble_q <= 1'b0;
            fwd_q    <= '0;
        end else begin
            cnt_q    <= cnt_d;
            busy_q   <= (cnt_d != '0);
            bubble_q <= stall;
            fwd_q    <= stall ? 4'b0000 : {exe2rs, exe2rt, mem2rs, mem2rt};
            if (hilo_haz && ((cnt_q > CNT_W'(1)) || load_use)) begin
                state_q <= HILO_WAIT;
            end else if (load_use) begin
                state_q <= LOAD_STALL;
            end else begin
                state_q <= RUN;
            end
        end
    end

    assign hz.Stall             = stall;
    assign hz.Bubble            = bubble_q;
    assign hz.forwardFromExe2rs = fwd_q[3];
    assign hz.forwardFromExe2rt = fwd_q[2];
    assign hz.forwardFromMem2rs = fwd_q[1];
    assign hz.forwardFromMem2rt = fwd_q[0];
    assign hz.MulDivBusy        = busy_q;
    assign hz.state             = state_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboarded bench for hazard_controller: stall, bubble, forwarding, mul/div wait, reset.
module tb_hazard_controller;
    import hazard_pkg::*;

    // ctl = {ValidID, RegWrite, RegDest, UsesRt, MemRead, MulDivStart, HiLoAccess}
    localparam logic [6:0] C_NOP  = 7'b0000000;
    localparam logic [6:0] C_ALU  = 7'b1111000;
    localparam logic [6:0] C_LW   = 7'b1100100;
    localparam logic [6:0] C_IMM  = 7'b1100000;
    localparam logic [6:0] C_MULT = 7'b1001010;
    localparam logic [6:0] C_MFHI = 7'b1110001;

    typedef struct {
        logic [31:0]   instr;
        logic [6:0]    ctl;
        logic          stall;
        logic [4:0]    exe;   // {Bubble, Exe2rs, Exe2rt, Mem2rs, Mem2rt} after the edge
        logic          busy;
        hazard_state_e st;
    } row_t;

    logic CLK = 1'b0;
    logic RESET = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] sb[$];

    hazard_controller_if hz ();

    hazard_controller #(
        .MULDIV_LATENCY (4),
        .CNT_W          (4)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .hz    (hz)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, got timeout want finish");
        $fatal(1);
    end

    function automatic logic [31:0] r_ins(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd);
        return {6'h00, rs, rt, rd, 11'h020};
    endfunction

    function automatic logic [31:0] i_ins(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [15:0] imm);
        return {6'h23, rs, rt, imm};
    endfunction

    function automatic row_t mk(input logic [31:0] instr, input logic [6:0] ctl,
                                input logic stall, input logic [4:0] exe, input logic busy,
                                input hazard_state_e st);
        row_t r;
        r.instr = instr;
        r.ctl   = ctl;
        r.stall = stall;
        r.exe   = exe;
        r.busy  = busy;
        r.st    = st;
        return r;
    endfunction

    task automatic drive(input row_t r);
        hz.Instr = r.instr;
        {hz.ValidID, hz.RegWrite, hz.RegDest, hz.UsesRt, hz.MemRead, hz.MulDivStart,
         hz.HiLoAccess} = r.ctl;
    endtask

    function automatic logic [7:0] observed();
        return {hz.Bubble, hz.forwardFromExe2rs, hz.forwardFromExe2rt, hz.forwardFromMem2rs,
                hz.forwardFromMem2rt, hz.MulDivBusy, hz.state};
    endfunction

    task automatic test_reset();
        logic [7:0] got;
        hz.Instr = r_ins(5'd1, 5'd2, 5'd3);
        {hz.ValidID, hz.RegWrite, hz.RegDest, hz.UsesRt, hz.MemRead, hz.MulDivStart,
         hz.HiLoAccess} = 7'b1111011;
        RESET = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        got = observed();
        checks++;
        if (got !== 8'h00) begin
            errors++;
            $display("FAIL reset_regs got=%b want=%b", got, 8'h00);
        end
        checks++;
        if (hz.Stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_stall got=%b want=0", hz.Stall);
        end
        drive(mk(32'h0, C_NOP, 1'b0, 5'b0, 1'b0, RUN));
        @(negedge CLK);
        RESET = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_exe_forward();
        row_t r[$];
        logic [7:0] got, want;
        r.push_back(mk(32'h0, C_NOP, 1'b0, 5'b00000, 1'b0, RUN));
        r.push_back(mk(32'h0, C_NOP, 1'b0, 5'b00000, 1'b0, RUN));
        r.push_back(mk(r_ins(5'd1, 5'd2, 5'd3), C_ALU, 1'b0, 5'b00000, 1'b0, RUN));
        r.push_back(mk(r_ins(5'd3, 5'd4, 5'd5), C_ALU, 1'b0, 5'b01000, 1'b0, RUN));
        r.push_back(mk(32'h0, C_NOP, 1'b0, 5'b00000, 1'b0, RUN));
        foreach (r[i]) begin
            drive(r[i]);
            @(negedge CLK);
            checks++;
            if (hz.Stall !== r[i].stall) begin
                errors++;
                $display("FAIL exe_fwd[%0d] stall got=%b want=%b", i, hz.Stall, r[i].stall);
            end
            sb.push_back({r[i].exe, r[i].busy, r[i].st});
            @(posedge CLK);
            #1;
            got  = observed();
            want = sb.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL exe_fwd[%0d] exe got=%b want=%b", i, got, want);
            end
        end
    endtask

    task automatic test_priority();
        row_t r[$];
        logic [7:0] got, want;
        r.push_back(mk(32'h0, C_NOP, 1'b0, 5'b00000, 1'b0, RUN));
        r.push_back(mk(32'h0, C_NOP, 1'b0, 5'b00000, 1'b0, RUN));
        r.push_back(mk(r_ins(5'd1, 5'd2, 5'd3), C_ALU, 1'b0, 5'b00000, 1'b0, RUN));
        r.push_back(mk(r_ins(5'd1, 5'd2, 5'd3), C_ALU, 1'b0, 5'b00000, 1'b0, RUN));
        r.push_back(mk(r_ins(5'd3, 5'd3, 5'd6), C_ALU, 1'b0, 5'b01100, 1'b0, RUN));
        r.push_back(mk(32'h0, C_NOP, 1'b0, 5'b00000, 1'b0, RUN));
        r.push_back(mk(r_ins(5'd1, 5'd2, 5'd3), C_ALU, 1'b0, 5'b00000, 1'b0, RUN));
        r.push_back(mk(32'h0, C_NOP, 1'b0, 5'b00000, 1'b0, RUN));
        r.push_back(mk(r_ins(5'd3, 5'd3, 5'd6), C_ALU, 1'b0, 5'b00011, 1'b0, RUN));
        foreach (r[i]) begin
            drive(r[i]);
            @(negedge CLK);
            checks++;
            if (hz.Stall !== r[i].stall) begin
                errors++;
                $display("FAIL priority[%0d] stall got=%b want=%b", i, hz.Stall, r[i].stall);
            end
            sb.push_back({r[i].exe, r[i].busy, r[i].st});
            @(posedge CLK);
            #1;
            got  = observed();
            want = sb.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL priority[%0d] exe got=%b want=%b", i, got, want);
            end
        end
    endtask

    task automatic test_load_use();
        row_t r[$];
        logic [7:0] got, want;
        r.push_back(mk(32'h0, C_NOP, 1'b0, 5'b00000, 1'b0, RUN));
        r.push_back(mk(32'h0, C_NOP, 1'b0, 5'b00000, 1'b0, RUN));
        r.push_back(mk(i_ins(5'd1, 5'd8, 16'h0), C_LW, 1'b0, 5'b00000, 1'b0, RUN));
        r.push_back(mk(r_ins(5'd8, 5'd2, 5'd9), C_ALU, 1'b1, 5'b10000, 1'b0, LOAD_STALL));
        r.push_back(mk(r_ins(5'd8, 5'd2, 5'd9), C_ALU, 1'b0, 5'b00010, 1'b0, RUN));
        r.push_back(mk(32'h0, C_NOP, 1'b0, 5'b00000, 1'b0, RUN));
        r.push_back(mk(i_ins(5'd1, 5'd8, 16'h0), C_LW, 1'b0, 5'b00000, 1'b0, RUN));
        r.push_back(mk(r_ins(5'd7, 5'd8, 5'd9), C_ALU, 1'b1, 5'b10000, 1'b0, LOAD_STALL));
        r.push_back(mk(r_ins(5'd7, 5'd8, 5'd9), C_ALU, 1'b0, 5'b00001, 1'b0, RUN));
        r.push_back(mk(32'h0, C_NOP, 1'b0, 5'b00000, 1'b0, RUN));
        foreach (r[i]) begin
            drive(r[i]);
            @(negedge CLK);
            checks++;
            if (hz.Stall !== r[i].stall) begin
                errors++;
                $display("FAIL load_use[%0d] stall got=%b want=%b", i, hz.Stall, r[i].stall);
            end
            sb.push_back({r[i].exe, r[i].busy, r[i].st});
            @(posedge CLK);
            #1;
            got  = observed();
            want = sb.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL load_use[%0d] exe got=%b want=%b", i, got, want);
            end
        end
    endtask

    task automatic test_zero_and_dest();
        row_t r[$];
        logic [7:0] got, want;
        r.push_back(mk(32'h0, C_NOP, 1'b0, 5'b00000, 1'b0, RUN));
        r.push_back(mk(32'h0, C_NOP, 1'b0, 5'b00000, 1'b0, RUN));
        r.push_back(mk(i_ins(5'd1, 5'd0, 16'h0), C_LW, 1'b0, 5'b00000, 1'b0, RUN));
        r.push_back(mk(r_ins(5'd0, 5'd0, 5'd5), C_ALU, 1'b0, 5'b00000, 1'b0, RUN));
        r.push_back(mk(32'h0, C_NOP, 1'b0, 5'b00000, 1'b0, RUN));
        // rd field holds r4 but RegDest=0 selects rt=r6 as the destination
        r.push_back(mk(i_ins(5'd1, 5'd6, 16'h2000), C_IMM, 1'b0, 5'b00000, 1'b0, RUN));
        r.push_back(mk(r_ins(5'd6, 5'd4, 5'd7), C_ALU, 1'b0, 5'b01000, 1'b0, RUN));
        r.push_back(mk(32'h0, C_NOP, 1'b0, 5'b00000, 1'b0, RUN));
        foreach (r[i]) begin
            drive(r[i]);
            @(negedge CLK);
            checks++;
            if (hz.Stall !== r[i].stall) begin
                errors++;
                $display("FAIL zero_dest[%0d] stall got=%b want=%b", i, hz.Stall, r[i].stall);
            end
            sb.push_back({r[i].exe, r[i].busy, r[i].st});
            @(posedge CLK);
            #1;
            got  = observed();
            want = sb.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL zero_dest[%0d] exe got=%b want=%b", i, got, want);
            end
        end
    endtask

    task automatic test_muldiv();
        row_t r[$];
        logic [7:0] got, want;
        r.push_back(mk(32'h0, C_NOP, 1'b0, 5'b00000, 1'b0, RUN));
        r.push_back(mk(32'h0, C_NOP, 1'b0, 5'b00000, 1'b0, RUN));
        r.push_back(mk(r_ins(5'd1, 5'd2, 5'd0), C_MULT, 1'b0, 5'b00000, 1'b1, RUN));
        r.push_back(mk(r_ins(5'd0, 5'd0, 5'd10), C_MFHI, 1'b1, 5'b10000, 1'b1, HILO_WAIT));
        r.push_back(mk(r_ins(5'd0, 5'd0, 5'd10), C_MFHI, 1'b1, 5'b10000, 1'b1, HILO_WAIT));
        r.push_back(mk(r_ins(5'd0, 5'd0, 5'd10), C_MFHI, 1'b1, 5'b10000, 1'b1, HILO_WAIT));
        r.push_back(mk(r_ins(5'd0, 5'd0, 5'd10), C_MFHI, 1'b1, 5'b10000, 1'b0, RUN));
        r.push_back(mk(r_ins(5'd0, 5'd0, 5'd10), C_MFHI, 1'b0, 5'b00000, 1'b0, RUN));
        r.push_back(mk(32'h0, C_NOP, 1'b0, 5'b00000, 1'b0, RUN));
        foreach (r[i]) begin
            drive(r[i]);
            @(negedge CLK);
            checks++;
            if (hz.Stall !== r[i].stall) begin
                errors++;
                $display("FAIL muldiv[%0d] stall got=%b want=%b", i, hz.Stall, r[i].stall);
            end
            sb.push_back({r[i].exe, r[i].busy, r[i].st});
            @(posedge CLK);
            #1;
            got  = observed();
            want = sb.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL muldiv[%0d] exe got=%b want=%b", i, got, want);
            end
        end
    endtask

    task automatic test_reset_mid_stall();
        row_t r[$];
        logic [7:0] got, want;
        r.push_back(mk(32'h0, C_NOP, 1'b0, 5'b00000, 1'b0, RUN));
        r.push_back(mk(r_ins(5'd1, 5'd2, 5'd0), C_MULT, 1'b0, 5'b00000, 1'b1, RUN));
        r.push_back(mk(r_ins(5'd0, 5'd0, 5'd10), C_MFHI, 1'b1, 5'b10000, 1'b1, HILO_WAIT));
        r.push_back(mk(r_ins(5'd0, 5'd0, 5'd10), C_MFHI, 1'b1, 5'b10000, 1'b1, HILO_WAIT));
        foreach (r[i]) begin
            drive(r[i]);
            @(negedge CLK);
            checks++;
            if (hz.Stall !== r[i].stall) begin
                errors++;
                $display("FAIL rst_mid[%0d] stall got=%b want=%b", i, hz.Stall, r[i].stall);
            end
            sb.push_back({r[i].exe, r[i].busy, r[i].st});
            @(posedge CLK);
            #1;
            got  = observed();
            want = sb.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL rst_mid[%0d] exe got=%b want=%b", i, got, want);
            end
        end
        // counter is now 2 with mfhi still held in ID
        checks++;
        if (hz.Stall !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid pre_stall got=%b want=1", hz.Stall);
        end
        RESET = 1'b0;
        #1;
        got = observed();
        checks++;
        if ({hz.Stall, got} !== 9'h000) begin
            errors++;
            $display("FAIL rst_mid async got=%b want=%b", {hz.Stall, got}, 9'h000);
        end
        @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
        #1;
        checks++;
        if (hz.Stall !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid release_stall got=%b want=0", hz.Stall);
        end
        @(posedge CLK);
        #1;
        got = observed();
        checks++;
        if (got !== {5'b00000, 1'b0, RUN}) begin
            errors++;
            $display("FAIL rst_mid restart got=%b want=%b", got, {5'b00000, 1'b0, RUN});
        end
    endtask

    initial begin
        test_reset();
        test_exe_forward();
        test_priority();
        test_load_use();
        test_zero_and_dest();
        test_muldiv();
        test_reset_mid_stall();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d want=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
